// File: rtl/ram_burst_wr_sr_nlane.sv
// ram_burst_wr_sr_nlane
//   Multi-lane burst-write RAM with a synchronous read port. Bursts of up to
//   LANES words are appended at an auto-incrementing write pointer. Fill level
//   is tracked for flow control and for flagging reads of unwritten locations.
//
// Optional build macro: RAM_BURST_RD_PIPE_EN
//   Defined   -> extra output register on the read path (read latency 2).
//   Undefined -> read latency 1.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (pointer, count, read regs)
//   clear      : synchronous buffer clear (pointer/count to 0, contents kept)
//   wr_valid   : burst write request
//   wr_ready   : burst can be accepted this cycle
//   wr_lanes   : number of valid lanes in the burst, lane 0 upward
//   wr_data    : lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_en      : read request
//   rd_addr    : read address
//   rd_data    : read data (holds its value when no read completes)
//   rd_valid   : rd_data holds the result of an accepted read
//   rd_oor     : the returned read was at an address >= fill_count
//   fill_count : words written since reset/clear
//   full       : fill_count == RAM_DEPTH
//
// Write handshake: a burst transfers on a rising edge where wr_valid and
// wr_ready are both high. wr_ready never looks at wr_valid or wr_lanes; it is
// low during rst or clear and whenever a full-width burst might not fit.
module ram_burst_wr_sr_nlane #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int LANES      = 7,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1,
    parameter int LW         = $clog2(LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [LW-1:0]               wr_lanes,
    input  logic [LANES*DATA_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic                        rd_oor,
    output logic [CNT_WIDTH-1:0]        fill_count,
    output logic                        full
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  fill_q, fill_d;
    logic [LW-1:0]         n_lanes;
    logic                  space_ok;
    logic                  wr_accept;
    logic                  rd_oor_now;

    // Conservative space check: assumes every burst may use all lanes, so no
    // burst can ever run past the end of the array (no wrap inside a burst).
    assign space_ok  = (32'(fill_q) + 32'(LANES)) <= 32'(RAM_DEPTH);
    assign wr_ready  = !rst && !clear && space_ok;
    assign wr_accept = wr_valid && wr_ready;

    // Requests for more lanes than exist are clamped to the full burst width.
    assign n_lanes = (wr_lanes > LW'(LANES)) ? LW'(LANES) : wr_lanes;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(n_lanes);
            fill_d   = fill_q + CNT_WIDTH'(n_lanes);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign fill_count = fill_q;
    assign full       = (fill_q == CNT_WIDTH'(RAM_DEPTH));

    // Storage is never reset; only lanes below n_lanes are written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (k < int'(n_lanes)) begin
                    mem_q[wr_ptr_q + ADDR_WIDTH'(k)] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Range check uses the count before this edge's write, and the array read
    // sees pre-write contents, giving read-before-write on a collision.
    assign rd_oor_now = CNT_WIDTH'(rd_addr) >= fill_q;

    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;
    logic                  s1_oor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_oor_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_en;
            s1_oor_q   <= rd_en && rd_oor_now;
            if (rd_en) begin
                s1_data_q <= rd_oor_now ? '0 : mem_q[rd_addr];
            end
        end
    end

`ifdef RAM_BURST_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_valid_q;
    logic                  s2_oor_q;

    // Data only advances with a valid result so rd_data keeps holding its
    // last returned value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_oor_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_oor_q   <= s1_oor_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
    assign rd_oor   = s2_oor_q;
`else
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
    assign rd_oor   = s1_oor_q;
`endif

endmodule

// File: tb/tb_ram_burst_wr_sr_nlane.sv
module tb_ram_burst_wr_sr_nlane;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int L     = 7;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(L + 1);
`ifdef RAM_BURST_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clear, wr_valid, wr_ready, rd_en, rd_valid, rd_oor, full;
    logic [LW-1:0]     wr_lanes;
    logic [L*DW-1:0]   wr_data;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic [CW-1:0]     fill_count;

    ram_burst_wr_sr_nlane dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_lanes   (wr_lanes),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_oor     (rd_oor),
        .fill_count (fill_count),
        .full       (full)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_s = 1'b0;
    always @(posedge clk) rst_s <= rst;

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    int            fill_m = 0;

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q[$];   // {oor, data}
    int            due_q[$];
    logic [DW-1:0] last_data = '0;
    bit            mon_en = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_s) last_data = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                chk("rd_valid", 64'(rd_valid), 64'd1);
                chk("rd_data", 64'(rd_data), 64'(exp_q[0][DW-1:0]));
                chk("rd_oor", 64'(rd_oor), 64'(exp_q[0][DW]));
                last_data = exp_q[0][DW-1:0];
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                chk("rd_valid_idle", 64'(rd_valid), 64'd0);
                chk("rd_data_hold", 64'(rd_data), 64'(last_data));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic c, input logic wv, input int wl,
                        input logic [L*DW-1:0] wd, input logic re, input int ra);
        bit exp_rdy;
        bit oor;
        int n;
        @(negedge clk);
        rst      = r;
        clear    = c;
        wr_valid = wv;
        wr_lanes = LW'(wl);
        wr_data  = wd;
        rd_en    = re;
        rd_addr  = AW'(ra);
        #1;
        exp_rdy = !r && !c && (fill_m + L <= DEPTH);
        chk("wr_ready", 64'(wr_ready), 64'(exp_rdy));
        if (!r && re) begin
            oor = (ra >= fill_m);
            exp_q.push_back({oor, oor ? 32'd0 : mem_m[ra]});
            due_q.push_back(cyc + LAT);
        end
        @(posedge clk);
        if (r) begin
            fill_m = 0;
            exp_q.delete();
            due_q.delete();
        end else if (c) begin
            fill_m = 0;
        end else if (wv && exp_rdy) begin
            n = (wl > L) ? L : wl;
            for (int k = 0; k < n; k++) mem_m[(fill_m + k) % DEPTH] = wd[k*DW +: DW];
            fill_m += n;
        end
        #1;
        chk("fill_count", 64'(fill_count), 64'(fill_m));
        chk("full", 64'(full), 64'(fill_m == DEPTH));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic burst(input int wl, input logic [L*DW-1:0] wd);
        step(0, 0, 1, wl, wd, 0, 0);
    endtask

    task automatic rd(input int ra);
        step(0, 0, 0, 0, '0, 1, ra);
    endtask

    function automatic logic [L*DW-1:0] seq_data(input int base);
        logic [L*DW-1:0] d;
        for (int k = 0; k < L; k++) d[k*DW +: DW] = DW'(base + k);
        return d;
    endfunction

    function automatic logic [L*DW-1:0] rnd_data();
        logic [L*DW-1:0] d;
        for (int k = 0; k < L; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; clear = 0; wr_valid = 0; wr_lanes = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
        do_reset();
        mon_en = 1;
        chk("reset_fill", 64'(fill_count), 64'd0);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_data", 64'(rd_data), 64'd0);

        // 1: one full burst, read back, then one past the end
        burst(7, seq_data(32'h100));
        chk("t1_fill", 64'(fill_count), 64'd7);
        for (int a = 0; a <= 7; a++) rd(a);
        repeat (3) idle();

        // 2: fill to 63, extra request ignored
        do_reset();
        for (int b = 0; b < 9; b++) burst(7, rnd_data());
        chk("t2_fill", 64'(fill_count), 64'd63);
        chk("t2_full", 64'(full), 64'd0);
        burst(7, rnd_data());
        chk("t2_fill_after", 64'(fill_count), 64'd63);
        rd(62); rd(63); rd(0);
        repeat (3) idle();

        // 3: partial and empty bursts
        do_reset();
        burst(3, seq_data(32'h300));
        chk("t3_fill_a", 64'(fill_count), 64'd3);
        burst(0, seq_data(32'h400));
        chk("t3_fill_b", 64'(fill_count), 64'd3);
        burst(5, seq_data(32'h500));
        chk("t3_fill_c", 64'(fill_count), 64'd8);
        for (int a = 0; a < 9; a++) rd(a);
        repeat (3) idle();

        // 4: read/write collision at address 7
        do_reset();
        burst(7, seq_data(32'h700));
        step(0, 0, 1, 7, seq_data(32'h800), 1, 7);
        rd(7);
        repeat (3) idle();

        // 5: clear together with a write
        do_reset();
        burst(7, seq_data(32'h900));
        burst(7, seq_data(32'h910));
        chk("t5_fill14", 64'(fill_count), 64'd14);
        step(0, 1, 1, 7, seq_data(32'hA00), 1, 3);
        chk("t5_fill0", 64'(fill_count), 64'd0);
        burst(7, seq_data(32'hB00));
        for (int a = 0; a < 8; a++) rd(a);
        repeat (3) idle();

        // 6: reset mid-stream with read and write pending
        burst(7, seq_data(32'hC00));
        rd(2);
        step(1, 0, 1, 7, seq_data(32'hD00), 1, 1);
        chk("t6_fill", 64'(fill_count), 64'd0);
        chk("t6_valid", 64'(rd_valid), 64'd0);
        chk("t6_data", 64'(rd_data), 64'd0);
        chk("t6_oor", 64'(rd_oor), 64'd0);
        burst(7, seq_data(32'hE00));
        rd(6);
        repeat (3) idle();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, L),
                 rnd_data(),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, DEPTH - 1));
        end
        repeat (4) idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
